// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between commit and the CSR file.
// Picks one winning event per committing instruction (interrupt, exception
// or ERTN), strobes the CSR update, flushes the pipeline for FLUSH_CYCLES
// cycles and then issues a single-cycle front-end redirect.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   commit_valid/ready           commit handshake (ready=0 stalls commit)
//   commit_pc/exc_vec/badv/ertn  committing instruction's trap information
//   hwi, ti, ipi                 level interrupt sources
//   ecfg_lie, crmd_ie            local / global interrupt enables
//   eentry, era                  redirect targets from the CSR file
//   is_exception, ertn_en        CSR update strobes
//   exception_cause/pc/addr      latched trap info for the CSR file
//   flush                        kill younger in-flight instructions
//   redirect_valid/pc            one-cycle front-end redirect
module exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CAUSE_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_valid,
  output logic               commit_ready,
  input  logic [31:0]        commit_pc,
  input  logic [15:0]        commit_exc_vec,
  input  logic [31:0]        commit_badv,
  input  logic               commit_ertn,
  input  logic [7:0]         hwi,
  input  logic               ti,
  input  logic               ipi,
  input  logic [12:0]        ecfg_lie,
  input  logic               crmd_ie,
  input  logic [31:0]        eentry,
  input  logic [31:0]        era,
  output logic               is_exception,
  output logic [CAUSE_W-1:0] exception_cause,
  output logic [31:0]        exception_pc,
  output logic [31:0]        exception_addr,
  output logic               ertn_en,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StTrap, StFlush, StRedir} state_e;
  typedef enum logic {KindExc, KindEret} kind_e;

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;

  logic [12:0] int_vec;
  logic        int_pend;
  logic        exc_hit;
  logic [3:0]  exc_code;
  logic [15:0] v;
  logic        unused_vec0;

  // Bit 10 has no interrupt source; bits 1:0 are software interrupts not wired here.
  assign int_vec     = {ipi, ti, 1'b0, hwi, 2'b00};
  assign int_pend    = crmd_ie & |(int_vec & ecfg_lie);
  assign v           = commit_exc_vec;
  assign unused_vec0 = commit_exc_vec[0];

  // Fixed architectural priority, interrupt first.
  always_comb begin
    exc_hit  = 1'b1;
    exc_code = 4'd0;
    if (int_pend)   exc_code = 4'd0;
    else if (v[6])  exc_code = 4'd6;
    else if (v[15]) exc_code = 4'd15;
    else if (v[3])  exc_code = 4'd3;
    else if (v[5])  exc_code = 4'd5;
    else if (v[11]) exc_code = 4'd11;
    else if (v[12]) exc_code = 4'd12;
    else if (v[13]) exc_code = 4'd13;
    else if (v[9])  exc_code = 4'd9;
    else if (v[10]) exc_code = 4'd10;
    else if (v[14]) exc_code = 4'd14;
    else if (v[8])  exc_code = 4'd8;
    else if (v[7])  exc_code = 4'd7;
    else if (v[1])  exc_code = 4'd1;
    else if (v[2])  exc_code = 4'd2;
    else if (v[4])  exc_code = 4'd4;
    else            exc_hit  = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (commit_valid) begin
          if (exc_hit) begin
            kind_d  = KindExc;
            cause_d = CAUSE_W'(exc_code);
            pc_d    = commit_pc;
            addr_d  = commit_badv;
            state_d = StTrap;
          end else if (commit_ertn) begin
            kind_d  = KindEret;
            state_d = StTrap;
          end
        end
      end
      StTrap: begin
        cnt_d   = CntW'(FLUSH_CYCLES - 1);
        state_d = StFlush;
      end
      StFlush: begin
        if (cnt_q == '0) state_d = StRedir;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StRedir: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kind_q  <= KindExc;
      cnt_q   <= '0;
      cause_q <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // All outputs decode from registered state only.
  assign commit_ready    = (state_q == StIdle);
  assign is_exception    = (state_q == StTrap) && (kind_q == KindExc);
  assign ertn_en         = (state_q == StTrap) && (kind_q == KindEret);
  assign flush           = (state_q == StTrap) || (state_q == StFlush);
  assign redirect_valid  = (state_q == StRedir);
  // Targets are read live in REDIR so they reflect the CSR write done in TRAP.
  assign redirect_pc     = redirect_valid ? ((kind_q == KindExc) ? eentry : era) : 32'h0;
  assign exception_cause = cause_q;
  assign exception_pc    = pc_q;
  assign exception_addr  = addr_q;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  localparam int unsigned FC = 2;
  localparam int unsigned PRIO[15] = '{6, 15, 3, 5, 11, 12, 13, 9, 10, 14, 8, 7, 1, 2, 4};

  logic        clk = 1'b0, rst = 1'b1;
  logic        commit_valid = 1'b0, commit_ready, commit_ertn = 1'b0;
  logic [31:0] commit_pc = '0, commit_badv = '0;
  logic [15:0] commit_exc_vec = '0;
  logic [7:0]  hwi = '0;
  logic        ti = 1'b0, ipi = 1'b0, crmd_ie = 1'b0;
  logic [12:0] ecfg_lie = '0;
  logic [31:0] eentry = 32'h1c008000, era = 32'h1c000204;
  logic        is_exception, ertn_en, flush, redirect_valid;
  logic [4:0]  exception_cause;
  logic [31:0] exception_pc, exception_addr, redirect_pc;

  typedef struct packed {
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] redir;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0, n_fail = 0;
  logic [4:0] last_cause = '0;

  exc_ctrl #(.FLUSH_CYCLES(FC), .CAUSE_W(5)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_exc_vec(commit_exc_vec), .commit_badv(commit_badv), .commit_ertn(commit_ertn),
    .hwi(hwi), .ti(ti), .ipi(ipi), .ecfg_lie(ecfg_lie), .crmd_ie(crmd_ie),
    .eentry(eentry), .era(era),
    .is_exception(is_exception), .exception_cause(exception_cause),
    .exception_pc(exception_pc), .exception_addr(exception_addr), .ertn_en(ertn_en),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_cause(input logic [15:0] vec);
    logic ip;
    ip = crmd_ie & |({ipi, ti, 1'b0, hwi, 2'b00} & ecfg_lie);
    if (ip) return 5'd0;
    for (int i = 0; i < 15; i++) if (vec[PRIO[i]]) return 5'(PRIO[i]);
    return 5'd31;
  endfunction

  // Full trigger-to-idle sequence with scoreboarded expectations.
  task automatic do_event(input string nm, input logic [15:0] vec, input logic ertn,
                          input logic [31:0] pc, input logic [31:0] badv,
                          input logic exp_exc, input logic [4:0] exp_cause);
    exp_t e;
    int   lat;
    @(negedge clk);
    commit_valid = 1'b1; commit_exc_vec = vec; commit_ertn = ertn;
    commit_pc = pc; commit_badv = badv;
    e.exc   = exp_exc;
    e.cause = exp_exc ? exp_cause : last_cause;
    e.pc    = exp_exc ? pc : exception_pc;
    e.addr  = exp_exc ? badv : exception_addr;
    e.redir = exp_exc ? eentry : era;
    sb_q.push_back(e);
    if (exp_exc) last_cause = exp_cause;
    n_cmp++;
    if (commit_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle: got %b want 1", nm, commit_ready);
    end
    lat = 0;
    do begin
      @(negedge clk);
      commit_valid = 1'b0; commit_exc_vec = '0; commit_ertn = 1'b0;
      lat++;
    end while (!(is_exception || ertn_en) && lat < 6);
    e = sb_q.pop_front();
    n_cmp++;
    if (lat != 1) begin
      n_fail++; $display("FAIL %s strobe_latency: got %0d want 1", nm, lat);
      return;
    end
    n_cmp++;
    if (is_exception !== e.exc || ertn_en !== !e.exc) begin
      n_fail++;
      $display("FAIL %s strobes: got exc=%b ertn=%b want exc=%b ertn=%b", nm,
               is_exception, ertn_en, e.exc, !e.exc);
    end
    n_cmp++;
    if (exception_cause !== e.cause || exception_pc !== e.pc || exception_addr !== e.addr) begin
      n_fail++;
      $display("FAIL %s trap_info: got %0d/%h/%h want %0d/%h/%h", nm, exception_cause,
               exception_pc, exception_addr, e.cause, e.pc, e.addr);
    end
    n_cmp++;
    if (flush !== 1'b1 || commit_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s trap_flush: got flush=%b ready=%b want 1/0", nm, flush,
                         commit_ready);
    end
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      n_cmp++;
      if (flush !== 1'b1 || redirect_valid !== 1'b0 || is_exception !== 1'b0 ||
          commit_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s flush_%0d: got flush=%b rv=%b exc=%b rdy=%b want 1/0/0/0", nm, i,
                 flush, redirect_valid, is_exception, commit_ready);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== e.redir || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL %s redirect: got rv=%b pc=%h flush=%b want 1/%h/0", nm, redirect_valid,
               redirect_pc, flush, e.redir);
    end
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b0 || commit_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s back_idle: got rv=%b rdy=%b want 0/1", nm, redirect_valid,
                         commit_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (commit_ready !== 1'b1 || flush !== 1'b0 || is_exception !== 1'b0 || ertn_en !== 1'b0 ||
        redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got rdy=%b fl=%b exc=%b ertn=%b rv=%b rpc=%h",
                         commit_ready, flush, is_exception, ertn_en, redirect_valid, redirect_pc);
    end
    n_cmp++;
    if (exception_cause !== 5'd0 || exception_pc !== 32'h0 || exception_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_info: got %0d/%h/%h want 0/0/0", exception_cause,
                         exception_pc, exception_addr);
    end
    rst = 1'b0;
    last_cause = '0;
  endtask

  task automatic test_sys;
    do_event("sys", 16'h0200, 1'b0, 32'h1c000100, 32'h0, 1'b1, 5'd9);
  endtask

  task automatic test_int_vs_exc;
    ti = 1'b1; ecfg_lie = 13'h0800; crmd_ie = 1'b1;
    do_event("int_wins", 16'h0800, 1'b0, 32'h1c000110, 32'h0, 1'b1, 5'd0);
    crmd_ie = 1'b0;
    do_event("int_masked", 16'h0800, 1'b0, 32'h1c000114, 32'h0, 1'b1, 5'd11);
    ti = 1'b0; hwi = 8'h08; ecfg_lie = 13'h0020; crmd_ie = 1'b1;
    do_event("hwi_only", 16'h0000, 1'b1, 32'h1c000118, 32'h0, 1'b1, 5'd0);
    hwi = '0; ecfg_lie = '0; crmd_ie = 1'b0;
  endtask

  task automatic test_ertn;
    do_event("ertn", 16'h0000, 1'b1, 32'h1c000200, 32'h0, 1'b0, 5'd0);
    do_event("ertn_brk", 16'h0400, 1'b1, 32'h1c000208, 32'h0, 1'b1, 5'd10);
  endtask

  task automatic test_priority;
    logic [15:0] vecs[5];
    vecs = '{16'h0142, 16'h4400, 16'h0082, 16'h8008, 16'h3000};
    do_event("multi_adef", vecs[0], 1'b0, 32'h1c000300, 32'h00000003, 1'b1, 5'd6);
    for (int i = 1; i < 5; i++)
      do_event("prio_tbl", vecs[i], 1'b0, 32'h1c000400 + 32'(i * 4), 32'(i), 1'b1,
               ref_cause(vecs[i]));
  endtask

  task automatic test_no_trigger;
    ti = 1'b1; ecfg_lie = 13'h0400; crmd_ie = 1'b1;
    @(negedge clk);
    commit_valid = 1'b1; commit_exc_vec = 16'h0001; commit_pc = 32'h1c000500;
    @(negedge clk);
    commit_valid = 1'b0; commit_exc_vec = '0;
    n_cmp++;
    if (is_exception !== 1'b0 || ertn_en !== 1'b0 || flush !== 1'b0 || commit_ready !== 1'b1) begin
      n_fail++; $display("FAIL no_trigger: got exc=%b ertn=%b fl=%b rdy=%b want 0/0/0/1",
                         is_exception, ertn_en, flush, commit_ready);
    end
    ti = 1'b0; ecfg_lie = '0; crmd_ie = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(negedge clk);
    commit_valid = 1'b1; commit_exc_vec = 16'h0200; commit_pc = 32'h1c000600; commit_badv = '0;
    @(negedge clk);
    n_cmp++;
    if (is_exception !== 1'b1 || exception_cause !== 5'd9) begin
      n_fail++; $display("FAIL b2b_first: got exc=%b cause=%0d want 1/9", is_exception,
                         exception_cause);
    end
    commit_exc_vec = 16'h0800; commit_pc = 32'h1c000604; commit_badv = 32'h55;
    e = '{exc: 1'b1, cause: 5'd11, pc: 32'h1c000604, addr: 32'h55, redir: eentry};
    sb_q.push_back(e);
    for (int i = 0; i <= FC; i++) begin
      @(negedge clk);
      n_cmp++;
      if (commit_ready !== 1'b0 || is_exception !== 1'b0 || redirect_valid !== (i == FC)) begin
        n_fail++; $display("FAIL b2b_stall_%0d: got rdy=%b exc=%b rv=%b", i, commit_ready,
                           is_exception, redirect_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (commit_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: got rdy=%b want 1", commit_ready);
    end
    @(negedge clk);
    commit_valid = 1'b0; commit_exc_vec = '0;
    e = sb_q.pop_front();
    n_cmp++;
    if (is_exception !== 1'b1 || exception_cause !== e.cause || exception_pc !== e.pc ||
        exception_addr !== e.addr) begin
      n_fail++; $display("FAIL b2b_second: got exc=%b %0d/%h/%h want 1/%0d/%h/%h", is_exception,
                         exception_cause, exception_pc, exception_addr, e.cause, e.pc, e.addr);
    end
    last_cause = 5'd11;
    repeat (FC + 2) @(negedge clk);
  endtask

  task automatic test_reset_in_flush;
    int seen;
    @(negedge clk);
    commit_valid = 1'b1; commit_exc_vec = 16'h0200; commit_pc = 32'h1c000700;
    @(negedge clk);
    commit_valid = 1'b0; commit_exc_vec = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0 || commit_ready !== 1'b1 ||
        exception_cause !== 5'd0 || exception_pc !== 32'h0) begin
      n_fail++; $display("FAIL rst_flush: got fl=%b rv=%b rdy=%b cause=%0d pc=%h want 0/0/1/0/0",
                         flush, redirect_valid, commit_ready, exception_cause, exception_pc);
    end
    seen = 0;
    repeat (FC + 4) begin
      @(negedge clk);
      if (redirect_valid !== 1'b0 || flush !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_no_redirect: got %0d active cycles want 0", seen);
    end
    last_cause = '0;
  endtask

  initial begin
    test_reset();
    test_sys();
    test_int_vs_exc();
    test_ertn();
    test_priority();
    test_no_trigger();
    test_back_to_back();
    test_reset_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer between the commit stage and the CSR file.
- Samples each committing instruction's exception flags, pending interrupts and ERTN, and picks one winning event.
- Drives the CSR update strobes (is_exception / ertn_en), then flushes the pipeline for a fixed drain period, then issues a one-cycle front-end redirect to EENTRY or ERA.
- Sole producer of the CSR file's is_exception, exception_cause, exception_pc and exception_addr inputs.

Parameters:
- FLUSH_CYCLES, 2, number of FLUSH-state cycles between the CSR update and the redirect (min 1).
- CAUSE_W, 5, width of exception_cause.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- commit_valid  in  1  instruction presented at commit this cycle
- commit_ready  out  1  commit accepted; 0 stalls commit
- commit_pc  in  32  PC of the committing instruction
- commit_exc_vec  in  16  bit i = cause code i raised (i=1..15); bit 0 ignored
- commit_badv  in  32  faulting virtual address of the committing instruction
- commit_ertn  in  1  committing instruction is ERTN
- hwi  in  8  hardware interrupt lines, level
- ti  in  1  timer interrupt, level
- ipi  in  1  inter-processor interrupt, level
- ecfg_lie  in  13  local interrupt enables (CSR ECFG[12:0])
- crmd_ie  in  1  global interrupt enable (CSR CRMD[2])
- eentry  in  32  exception entry (CSR EENTRY)
- era  in  32  return address (CSR ERA)
- is_exception  out  1  CSR exception-update strobe
- exception_cause  out  CAUSE_W  winning cause code
- exception_pc  out  32  PC written to ERA
- exception_addr  out  32  address written to BADV
- ertn_en  out  1  CSR ERTN-restore strobe
- flush  out  1  kill all younger in-flight instructions
- redirect_valid  out  1  one-cycle front-end redirect
- redirect_pc  out  32  redirect target

Behaviour:
- Cause codes: 0 INT, 1 PIL, 2 PIS, 3 PIF, 4 PME, 5 PPI, 6 ADEF, 7 ADEM, 8 ALE, 9 SYS, 10 BRK, 11 INE, 12 IPE, 13 FPD, 14 FPE, 15 TLBR.
- int_pend = crmd_ie & |({ipi, ti, 1'b0, hwi, 2'b0} & ecfg_lie). Combinational; no interrupt latching inside this block.
- Trigger is evaluated only when state == IDLE and commit_valid == 1.
- Priority, highest first: INT, ADEF, TLBR, PIF, PPI, INE, IPE, FPD, SYS, BRK, FPE, ALE, ADEM, PIL, PIS, PME, then ERTN.
- Exception or INT wins over ERTN; ERTN is dropped and ertn_en is never asserted.
- FSM states: IDLE, TRAP, FLUSH, REDIR.
- IDLE:
  - commit_ready = 1.
  - If an exception or INT is present: latch cause, commit_pc and commit_badv into output registers; set kind = EXC; go to TRAP.
  - Else if commit_ertn: set kind = ERET; go to TRAP.
  - Otherwise remain in IDLE; normal commit passes through.
- TRAP (1 cycle):
  - is_exception = (kind == EXC); ertn_en = (kind == ERET).
  - flush = 1; commit_ready = 0.
  - Next state: FLUSH; counter loads FLUSH_CYCLES-1.
- FLUSH:
  - flush = 1; commit_ready = 0.
  - Counter decrements each cycle; at 0, go to REDIR.
- REDIR (1 cycle):
  - redirect_valid = 1; flush = 0; commit_ready = 0.
  - redirect_pc = eentry if kind == EXC, else era. Sampled in this cycle, so it sees the CSR state after the TRAP write.
  - Next state: IDLE.
- Outputs are registered; the TRAP strobe appears the cycle after the triggering commit.
- Event-to-redirect latency: 1 (TRAP) + FLUSH_CYCLES + 1 (REDIR) cycles after the triggering edge.
- exception_cause, exception_pc and exception_addr hold their latched values until the next trigger. They are valid whenever is_exception = 1.
- commit_valid outside IDLE is ignored; the upstream stage must hold, since commit_ready = 0.
- Interrupt changes outside IDLE are ignored.
- Back-to-back: a new trigger may be accepted in the first IDLE cycle after REDIR.
- Reset (also mid-sequence):
  - State returns to IDLE.
  - All outputs become 0 except commit_ready = 1.
  - Latched cause/pc/addr registers are cleared to 0.
  - Any in-progress strobe or redirect is abandoned.

Test Plan:
- SYS at commit: commit_pc=0x1c000100, exc_vec bit 9 -> next cycle is_exception=1, cause=9, exception_pc=0x1c000100; flush=1 for 1+FLUSH_CYCLES cycles; then redirect_valid=1 with redirect_pc=eentry (0x1c008000).
- INT vs exception: ti=1, ecfg_lie[11]=1, crmd_ie=1, exc_vec bit 11 (INE) -> cause=0. Repeat with crmd_ie=0 -> cause=11.
- ERTN: commit_ertn=1, era=0x1c000204 -> ertn_en=1 and is_exception=0 in TRAP; redirect_pc=0x1c000204. Same with exc_vec bit 10 -> only is_exception with cause=10.
- Multi-cause priority: exc_vec bits 1,8,6 (PIL, ALE, ADEF) -> cause=6; commit_badv=0x00000003 -> exception_addr=0x00000003.
- Stall: commit_valid held with a second exception during FLUSH -> commit_ready=0 and no second TRAP; it is accepted on the first IDLE cycle after REDIR.
- Reset in FLUSH -> next cycle flush=0, redirect_valid=0, commit_ready=1, cause=0; no redirect is ever issued.
